// File: rtl/conv_pkg.sv
// Shared fixed-point geometry, the beat record carried through the stream, and ReLU/requant arithmetic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

    localparam int N_FILTERS  = 64;
    localparam int H_OUT      = 5;
    localparam int W_OUT      = 5;
    localparam int DATA_WIDTH = 18;
    localparam int FRAC_WIDTH = 8;
    localparam int OUT_WIDTH  = 8;
    localparam int OUT_FRAC   = 4;
    localparam int SHIFT      = FRAC_WIDTH - OUT_FRAC;

    localparam int N_WORDS    = N_FILTERS * H_OUT * W_OUT;
    localparam int ADDR_WIDTH = $clog2(N_WORDS);
    localparam int FILT_WIDTH = $clog2(N_FILTERS);
    localparam int ROW_WIDTH  = $clog2(H_OUT);
    localparam int COL_WIDTH  = $clog2(W_OUT);

    // One stream beat: requantised value plus its position tags.
    typedef struct packed {
        logic [OUT_WIDTH-1:0]  data;
        logic [FILT_WIDTH-1:0] filt;
        logic [ROW_WIDTH-1:0]  row;
        logic [COL_WIDTH-1:0]  col;
        logic                  last;
        logic                  last_all;
    } beat_t;

    localparam logic [DATA_WIDTH:0] ROUND_ADD = (DATA_WIDTH+1)'(2 ** (SHIFT - 1));
    localparam logic [DATA_WIDTH:0] OUT_MAX   = (DATA_WIDTH+1)'(2 ** OUT_WIDTH - 1);

    // Clamp negatives to zero, round half up while dropping SHIFT fraction bits, saturate.
    // The sum is one bit wider than the input so the rounding add can never wrap.
    function automatic logic [OUT_WIDTH-1:0] relu_requant(input logic signed [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] r;
        logic [DATA_WIDTH:0] q;
        r = x[DATA_WIDTH-1] ? '0 : {1'b0, x};
        q = (r + ROUND_ADD) >> SHIFT;
        if (q > OUT_MAX)
            return '1;
        return q[OUT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/conv_stream_fifo.sv
// Two-entry beat FIFO that decouples Y reads from the downstream stream handshake.
// Latency: a pushed beat is at the head the cycle after the push.
// Backpressure: writer must respect count; pop is ignored when empty, push is dropped only if full without a pop.
module conv_stream_fifo
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  do_push;
    logic  do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so an empty FIFO presents zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_output_streamer.sv
// Drains Y after conv done: reads every word, applies ReLU + requant, streams tagged beats.
// Latency: first beat valid 2 cycles after start (read, capture); 1 beat/cycle with ready held high.
// Backpressure: reads issue only while FIFO + in-flight slots remain, so stalls never lose or duplicate beats.
module conv_output_streamer
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic [FILT_WIDTH-1:0] m_filt,
    output logic [ROW_WIDTH-1:0]  m_row,
    output logic [COL_WIDTH-1:0]  m_col,
    output logic                  m_last,
    output logic                  m_last_all
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [FILT_WIDTH-1:0] F_LAST = FILT_WIDTH'(N_FILTERS - 1);
    localparam logic [ROW_WIDTH-1:0]  R_LAST = ROW_WIDTH'(H_OUT - 1);
    localparam logic [COL_WIDTH-1:0]  C_LAST = COL_WIDTH'(W_OUT - 1);

    logic [1:0]            state;
    logic [FILT_WIDTH-1:0] f_cnt;
    logic [ROW_WIDTH-1:0]  row_cnt;
    logic [COL_WIDTH-1:0]  col_cnt;

    logic                  inflight;
    logic [FILT_WIDTH-1:0] infl_filt;
    logic [ROW_WIDTH-1:0]  infl_row;
    logic [COL_WIDTH-1:0]  infl_col;
    logic                  infl_last;
    logic                  infl_last_all;

    logic [1:0] fifo_count;
    beat_t      head;
    beat_t      push_beat;
    logic       pop;
    logic [2:0] occ;
    logic       issue;
    logic       last_map;
    logic       last_word;

    // Slots already committed after this cycle's pop; a read is only issued if one is still free.
    assign pop       = m_valid && m_ready;
    assign occ       = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue     = (state == S_RUN) && (occ < 3'd2);
    assign last_map  = (row_cnt == R_LAST) && (col_cnt == C_LAST);
    assign last_word = last_map && (f_cnt == F_LAST);

    assign rd_en = issue;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_FIN);

    // Control FSM; start is honoured only from IDLE, so a start during FIN is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (issue && last_word) state <= S_DRAIN;
                S_DRAIN: if (pop && head.last_all) state <= S_FIN;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read address and f/i/j position counters advance together with each issued read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
            f_cnt   <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            rd_addr <= '0;
            f_cnt   <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (issue) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            if (col_cnt == C_LAST) begin
                col_cnt <= '0;
                if (row_cnt == R_LAST) begin
                    row_cnt <= '0;
                    f_cnt   <= f_cnt + FILT_WIDTH'(1);
                end else begin
                    row_cnt <= row_cnt + ROW_WIDTH'(1);
                end
            end else begin
                col_cnt <= col_cnt + COL_WIDTH'(1);
            end
        end
    end

    // Hold the tags of the read in flight so they meet their data one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            infl_filt     <= '0;
            infl_row      <= '0;
            infl_col      <= '0;
            infl_last     <= 1'b0;
            infl_last_all <= 1'b0;
        end else begin
            inflight      <= issue;
            infl_filt     <= f_cnt;
            infl_row      <= row_cnt;
            infl_col      <= col_cnt;
            infl_last     <= last_map;
            infl_last_all <= last_word;
        end
    end

    assign push_beat.data     = relu_requant(rd_data);
    assign push_beat.filt     = infl_filt;
    assign push_beat.row      = infl_row;
    assign push_beat.col      = infl_col;
    assign push_beat.last     = infl_last;
    assign push_beat.last_all = infl_last_all;

    conv_stream_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign m_valid    = (fifo_count != 2'd0);
    assign m_data     = head.data;
    assign m_filt     = head.filt;
    assign m_row      = head.row;
    assign m_col      = head.col;
    assign m_last     = head.last;
    assign m_last_all = head.last_all;

endmodule

// File: tb/tb_conv_output_streamer.sv
module tb_conv_output_streamer;
    import conv_pkg::*;

    localparam int BW = OUT_WIDTH + FILT_WIDTH + ROW_WIDTH + COL_WIDTH + 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [OUT_WIDTH-1:0]  m_data;
    logic [FILT_WIDTH-1:0] m_filt;
    logic [ROW_WIDTH-1:0]  m_row;
    logic [COL_WIDTH-1:0]  m_col;
    logic                  m_last;
    logic                  m_last_all;

    conv_output_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_filt     (m_filt),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_last     (m_last),
        .m_last_all (m_last_all)
    );

    always #5 clk = ~clk;

    logic signed [DATA_WIDTH-1:0] ymem [N_WORDS];
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] got;
    assign got = {m_data, m_filt, m_row, m_col, m_last, m_last_all};

    int errors = 0;
    int checks = 0;
    int beats, dones, first_k, last_k, done_k, max_occ, last_cnt, lastall_cnt;

    // Y memory with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= ymem[rd_addr];
    end

    function automatic int model_q(input logic signed [DATA_WIDTH-1:0] x);
        int v;
        v = int'(x);
        if (v < 0) return 0;
        v = (v + 8) / 16;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int a, input int d);
        int f, i, j;
        f = a / (H_OUT * W_OUT);
        i = (a % (H_OUT * W_OUT)) / W_OUT;
        j = a % W_OUT;
        return {OUT_WIDTH'(d), FILT_WIDTH'(f), ROW_WIDTH'(i), COL_WIDTH'(j),
                (i == H_OUT-1 && j == W_OUT-1),
                (i == H_OUT-1 && j == W_OUT-1 && f == N_FILTERS-1)};
    endfunction

    task automatic fill_queue();
        exp_q.delete();
        for (int a = 0; a < N_WORDS; a++)
            exp_q.push_back(exp_beat(a, model_q(ymem[a])));
    endtask

    task automatic run_drain(input bit rnd_ready, input int stall_at, input int rst_at,
                             input bit busy_start, input bit fin_start, input bit t1_timing);
        int k = 0;
        int issued = 0;
        int exp_addr = 0;
        int stall_left = 20;
        int done_at = -1;
        int late_bad = 0;
        bit stalled_prev = 1'b0;
        bit aborted = 1'b0;
        bit do_rst = 1'b0;
        logic [BW-1:0] held;
        logic [BW-1:0] want;
        held = '0;
        beats = 0; dones = 0; first_k = -1; last_k = -1; done_k = -1;
        max_occ = 0; last_cnt = 0; lastall_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (k < 8000) begin
            if (do_rst) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({m_valid, busy, done, rd_en} !== 4'b0) begin
                    errors++;
                    $display("FAIL mid_rst_ctrl valid/busy/done/rd_en=%b want 0000", {m_valid, busy, done, rd_en});
                end
                checks++;
                if ({rd_addr, got} !== '0) begin
                    errors++;
                    $display("FAIL mid_rst_data addr=%0d beat=%h want 0", rd_addr, got);
                end
                @(posedge clk); #1 rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            start = busy_start && (k == 500);
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_at >= 0 && beats >= stall_at && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end
            @(negedge clk);
            if (stalled_prev) begin
                checks++;
                if (!m_valid || got !== held) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d valid=%b got=%h want=%h", k, m_valid, got, held);
                end
            end
            stalled_prev = m_valid && !m_ready;
            held = got;
            if (rd_en) begin
                checks++;
                if (rd_addr !== ADDR_WIDTH'(exp_addr)) begin
                    errors++;
                    $display("FAIL rd_addr k=%0d got=%0d want=%0d", k, rd_addr, exp_addr);
                end
                exp_addr++;
                issued++;
            end
            if (m_valid && m_ready) begin
                if (first_k < 0) first_k = k;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat k=%0d got=%h", k, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL beat n=%0d got=%h want=%h", beats, got, want);
                    end
                end
                beats++;
                if (m_last) last_cnt++;
                if (m_last_all) begin
                    lastall_cnt++;
                    last_k = k;
                end
            end
            if (issued - beats > max_occ) max_occ = issued - beats;
            if (done) begin
                dones++;
                done_k = k;
                if (done_at < 0) done_at = k;
                if (fin_start) start = 1'b1;
            end
            do_rst = (rst_at >= 0) && (beats == rst_at);
            if (done_at >= 0 && k >= done_at + 4) break;
            @(posedge clk); k++; #1;
        end
        if (aborted) begin
            exp_q.delete();
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (done || m_valid || busy) late_bad++;
            end
            checks++;
            if (late_bad != 0) begin
                errors++;
                $display("FAIL post_rst_quiet bad_cycles=%0d want 0", late_bad);
            end
        end else begin
            checks++;
            if (beats != N_WORDS) begin errors++; $display("FAIL beat_count got=%0d want=%0d", beats, N_WORDS); end
            checks++;
            if (dones != 1) begin errors++; $display("FAIL done_pulses got=%0d want=1", dones); end
            checks++;
            if (exp_q.size() != 0) begin errors++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
            checks++;
            if (max_occ > 2) begin errors++; $display("FAIL outstanding got=%0d want<=2", max_occ); end
            checks++;
            if (last_cnt != N_FILTERS || lastall_cnt != 1) begin
                errors++;
                $display("FAIL last_flags last=%0d last_all=%0d want %0d/1", last_cnt, lastall_cnt, N_FILTERS);
            end
            checks++;
            if (done_k != last_k + 1) begin errors++; $display("FAIL done_timing got=%0d want=%0d", done_k, last_k + 1); end
            checks++;
            if ({busy, m_valid, rd_en} !== 3'b000) begin
                errors++;
                $display("FAIL idle_after busy/valid/rd_en=%b want 000", {busy, m_valid, rd_en});
            end
            if (t1_timing) begin
                checks++;
                if (first_k != 2) begin errors++; $display("FAIL first_valid got=%0d want=2", first_k); end
                checks++;
                if (last_k != 1601) begin errors++; $display("FAIL last_beat_cycle got=%0d want=1601", last_k); end
            end
        end
        start = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; m_ready = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got=%b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done got=%b want 0", done); end
        checks++; if (rd_en !== 1'b0)  begin errors++; $display("FAIL rst_rd_en got=%b want 0", rd_en); end
        checks++; if (rd_addr !== '0)  begin errors++; $display("FAIL rst_rd_addr got=%0d want 0", rd_addr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b want 0", m_valid); end
        checks++; if (got !== '0)      begin errors++; $display("FAIL rst_beat got=%h want 0", got); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_constant();
        for (int a = 0; a < N_WORDS; a++) ymem[a] = DATA_WIDTH'(1536);
        fill_queue();
        run_drain(1'b0, -1, -1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_arith();
        int lit [5] = '{0, 0, 96, 97, 255};
        for (int a = 0; a < N_WORDS; a++) ymem[a] = DATA_WIDTH'($urandom);
        ymem[0] = -18'sd256;
        ymem[1] = 18'sd0;
        ymem[2] = 18'sd1543;
        ymem[3] = 18'sd1544;
        ymem[4] = 18'sd131071;
        fill_queue();
        for (int n = 0; n < 5; n++) exp_q[n] = exp_beat(n, lit[n]);
        run_drain(1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_order_random();
        for (int a = 0; a < N_WORDS; a++)
            ymem[a] = DATA_WIDTH'((a / 25) * 256 + (a % 25));
        fill_queue();
        run_drain(1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        for (int a = 0; a < N_WORDS; a++) ymem[a] = DATA_WIDTH'($urandom_range(0, 8191));
        fill_queue();
        run_drain(1'b0, 300, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_queue();
        run_drain(1'b0, -1, -1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_queue();
        run_drain(1'b0, -1, 700, 1'b0, 1'b0, 1'b0);
        fill_queue();
        run_drain(1'b0, -1, -1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_arith();
        test_order_random();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
